ex_wb_stage: RTL and testbench

//  Pipeline stage directly downstream of the ALU: captures EX_out plus destination info, presents
//  it to the register-file write port with a valid/ready handshake. 2-entry skid buffer so ALU-side

---
 rtl/ex_wb_pkg.sv | 14 +
 rtl/wb_skid_buf.sv | 77 +++++++
 rtl/ex_wb_stage.sv | 77 +++++++
 tb/tb_ex_wb_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pkg.sv
// Shared definitions for the EX->WB stage: default widths and the
// occupancy encoding of the 2-entry skid buffer.
package ex_wb_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CTRL_W  = 5;
  localparam int DEF_RADDR_W = 4;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;
endpackage

// File: rtl/wb_skid_buf.sv
// 2-entry valid/ready skid buffer with a registered upstream ready.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is a flop)
//   in_data [W]           upstream payload
//   out_valid/out_ready   downstream handshake, out_data = head entry
// Order is strict FIFO: the skid entry only ever refills the head.
module wb_skid_buf
  import ex_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  occ_t         state, state_nxt;
  logic [W-1:0] head, skid;
  logic         ready_q;
  logic         acc, ret;
  logic         ld_head_in, ld_head_skid, ld_skid;

  assign acc       = in_valid & ready_q;
  assign ret       = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = head;
  assign in_ready  = ready_q;

  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: if (acc) begin
        state_nxt  = ST_ONE;
        ld_head_in = 1'b1;
      end
      ST_ONE: begin
        if (acc && ret) begin
          ld_head_in = 1'b1;          // head drains and refills in one cycle
        end else if (acc) begin
          state_nxt = ST_FULL;
          ld_skid   = 1'b1;
        end else if (ret) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (ret) begin         // ready_q is low here, so no accept
        state_nxt    = ST_ONE;
        ld_head_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      // Registered ready: computed from the next occupancy, not combinationally from out_ready.
      ready_q <= (state_nxt != ST_FULL);
      if (ld_head_in)        head <= in_data;
      else if (ld_head_skid) head <= skid;
      if (ld_skid)           skid <= in_data;
    end
  end
endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline stage. Buffers ALU results (with rd/we/ctrl) in a 2-entry
// skid buffer and presents the head to the register-file write port.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ex_valid/ex_ready, ex_*          ALU-side handshake and payload
//   wb_valid/wb_ready, wb_*          register-file side handshake and head payload
//   fwd_valid/fwd_rd/fwd_data        bypass of the head entry only
//   flag_z/flag_n                    zero/negative of the last retired result
//   retire_cnt                       count of retired ops (wraps)
module ex_wb_stage
  import ex_wb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [CTRL_W-1:0]  ex_ctrl,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_we,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_we,
  output logic [CTRL_W-1:0]  wb_ctrl,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               flag_z,
  output logic               flag_n,
  output logic [CNT_W-1:0]   retire_cnt
);
  localparam int PW = CTRL_W + 1 + RADDR_W + DATA_W;

  logic [PW-1:0] pl_in, pl_out;
  logic          retire;

  assign pl_in = {ex_ctrl, ex_we, ex_rd, ex_result};

  wb_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (pl_in),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_data  (pl_out)
  );

  assign {wb_ctrl, wb_we, wb_rd, wb_data} = pl_out;

  assign fwd_valid = wb_valid & wb_we;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;

  assign retire = wb_valid & wb_ready;

  // Flags track every retired op, including those with we=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      retire_cnt <= '0;
    end else if (retire) begin
      flag_z     <= (wb_data == '0);
      flag_n     <= wb_data[DATA_W-1];
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_ctrl;
  logic [3:0]  ex_rd;
  logic        ex_we;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [4:0]  wb_ctrl;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        flag_z, flag_n;
  logic [15:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_we(ex_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_ctrl(wb_ctrl),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flag_z(flag_z), .flag_n(flag_n), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [4:0]  ctrl;
    logic [3:0]  rd;
    logic        we;
    logic        wbr;
    logic        e_wv;
    logic [31:0] e_data;
    logic [3:0]  e_rd;
    logic        e_we;
    logic [4:0]  e_ctrl;
    logic        e_rdy;
    logic [15:0] e_cnt;
    logic        e_z;
    logic        e_n;
    logic        e_fv;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: vld data ctrl rd we wbr | wv data rd we ctrl rdy cnt z n fv
    // Stream of 5, 0, 0x80000000 with wb_ready=1
    tbl[0]  = '{1, 32'h5,        1, 1, 1, 1,  1, 32'h5,        1, 1, 1,  1, 0, 0, 0, 1};
    tbl[1]  = '{1, 32'h0,        2, 2, 1, 1,  1, 32'h0,        2, 1, 2,  1, 1, 0, 0, 1};
    tbl[2]  = '{1, 32'h80000000, 3, 3, 1, 1,  1, 32'h80000000, 3, 1, 3,  1, 2, 1, 0, 1};
    tbl[3]  = '{0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0, 0,  1, 3, 0, 1, 0};
    // Backpressure: A=0x11, B=0x22 fill the buffer; 0x99 offered while full is dropped
    tbl[4]  = '{1, 32'h11,       4, 4, 1, 0,  1, 32'h11,       4, 1, 4,  1, 3, 0, 1, 1};
    tbl[5]  = '{1, 32'h22,       5, 5, 1, 0,  1, 32'h11,       4, 1, 4,  0, 3, 0, 1, 1};
    tbl[6]  = '{1, 32'h99,       6, 6, 1, 0,  1, 32'h11,       4, 1, 4,  0, 3, 0, 1, 1};
    tbl[7]  = '{0, 32'h0,        0, 0, 0, 1,  1, 32'h22,       5, 1, 5,  1, 4, 0, 0, 1};
    tbl[8]  = '{0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0, 0,  1, 5, 0, 0, 0};
    // Accept 0x33 in the same cycle the head retires
    tbl[9]  = '{1, 32'hAA,       9, 6, 1, 0,  1, 32'hAA,       6, 1, 9,  1, 5, 0, 0, 1};
    tbl[10] = '{1, 32'h33,      10, 7, 1, 1,  1, 32'h33,       7, 1, 10, 1, 6, 0, 0, 1};
    tbl[11] = '{0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0, 0,  1, 7, 0, 0, 0};
    // Forwarding: rd=3 data=7 held, then a we=0 op with zero result
    tbl[12] = '{1, 32'h7,       12, 3, 1, 0,  1, 32'h7,        3, 1, 12, 1, 7, 0, 0, 1};
    tbl[13] = '{0, 32'h0,        0, 0, 0, 0,  1, 32'h7,        3, 1, 12, 1, 7, 0, 0, 1};
    tbl[14] = '{0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0, 0,  1, 8, 0, 0, 0};
    tbl[15] = '{1, 32'h0,       15, 9, 0, 0,  1, 32'h0,        9, 0, 15, 1, 8, 0, 0, 0};
    tbl[16] = '{0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0, 0,  1, 9, 1, 0, 0};

    // Reset held 2 cycles with ex_valid asserted
    rst_n = 1'b0; ex_valid = 1'b1; ex_result = 32'h123; ex_ctrl = 5'd1;
    ex_rd = 4'd1; ex_we = 1'b1; wb_ready = 1'b0;
    step; step;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
    chk("rst_flag_n", {31'd0, flag_n}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    ex_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ex_valid  = tbl[i].vld;
      ex_result = tbl[i].vld ? tbl[i].data : 'x;
      ex_ctrl   = tbl[i].vld ? tbl[i].ctrl : 'x;
      ex_rd     = tbl[i].vld ? tbl[i].rd   : 'x;
      ex_we     = tbl[i].vld ? tbl[i].we   : 1'bx;
      wb_ready  = tbl[i].wbr;
      step;
      chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, {31'd0, tbl[i].e_wv});
      chk($sformatf("v%0d_ex_ready", i), {31'd0, ex_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_cnt", i), {16'd0, retire_cnt}, {16'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_flag_z", i), {31'd0, flag_z}, {31'd0, tbl[i].e_z});
      chk($sformatf("v%0d_flag_n", i), {31'd0, flag_n}, {31'd0, tbl[i].e_n});
      chk($sformatf("v%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, tbl[i].e_fv});
      if (tbl[i].e_wv) begin
        chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].e_data);
        chk($sformatf("v%0d_wb_rd", i), {28'd0, wb_rd}, {28'd0, tbl[i].e_rd});
        chk($sformatf("v%0d_wb_we", i), {31'd0, wb_we}, {31'd0, tbl[i].e_we});
        chk($sformatf("v%0d_wb_ctrl", i), {27'd0, wb_ctrl}, {27'd0, tbl[i].e_ctrl});
        chk($sformatf("v%0d_fwd_rd", i), {28'd0, fwd_rd}, {28'd0, tbl[i].e_rd});
        chk($sformatf("v%0d_fwd_data", i), fwd_data, tbl[i].e_data);
      end
    end

    // Counter wrap: 65535 retirements after a fresh reset, then one more
    ex_valid = 1'b0; rst_n = 1'b0; step; rst_n = 1'b1;
    chk("wrap_cnt_start", {16'd0, retire_cnt}, 32'd0);
    ex_valid = 1'b1; ex_result = 32'h1; ex_ctrl = 5'd0; ex_rd = 4'd1; ex_we = 1'b1;
    wb_ready = 1'b1;
    repeat (65535) step;
    ex_valid = 1'b0;
    step;
    chk("wrap_cnt_max", {16'd0, retire_cnt}, 32'd65535);
    chk("wrap_empty", {31'd0, wb_valid}, 32'd0);
    ex_valid = 1'b1; ex_result = 32'hFFFFFFFF;
    step;
    ex_valid = 1'b0;
    step;
    chk("wrap_cnt_zero", {16'd0, retire_cnt}, 32'd0);
    chk("wrap_flag_n", {31'd0, flag_n}, 32'd1);
    chk("wrap_flag_z", {31'd0, flag_z}, 32'd0);

    // Reset while FULL drops both entries
    wb_ready = 1'b0;
    ex_valid = 1'b1; ex_result = 32'h44; step;
    ex_result = 32'h55; step;
    ex_valid = 1'b0;
    chk("full_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("full_wb_data", wb_data, 32'h44);
    rst_n = 1'b0; step; rst_n = 1'b1;
    chk("frst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("frst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("frst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("frst_flag_n", {31'd0, flag_n}, 32'd0);
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("post_rst%0d_wb_valid", k), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("post_rst%0d_cnt", k), {16'd0, retire_cnt}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
